// File: rtl/instr_mem_pipe.sv
// Instruction memory filled word-by-word by a loader (LOAD) and read by a
// LAT-stage fetch pipeline (RUN) that reports misaligned/unloaded fetches as faults.
module instr_mem_pipe #(
  parameter int          DEPTH     = 256,
  parameter int          LAT       = 1,
  parameter logic [31:0] FILL_WORD = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  input  logic                   ld_start,
  input  logic                   req_valid,
  input  logic [31:0]            req_addr,
  output logic                   req_ready,
  output logic                   resp_valid,
  output logic [31:0]            resp_data,
  output logic                   resp_fault,
  input  logic                   resp_ready,
  output logic [$clog2(DEPTH):0] loaded_words
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  typedef enum logic {LOAD, RUN} state_t;

  state_t        state;
  logic          start_pend;
  logic          start_req;
  logic          advance;
  logic          accept;
  logic          in_flight;
  logic          stage_busy;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] req_idx;
  logic          req_fault;
  logic [31:0]   rd_word;
  logic          vld_in;
  logic          fault_in;
  logic [31:0]   data_in;

  function automatic logic fetch_fault(input logic [31:0] addr, input logic [AW:0] cnt);
    logic [29:0] widx;
    widx = addr[31:2];
    return (addr[1:0] != 2'b00) || (widx >= 30'(DEPTH)) || (widx >= 30'(cnt));
  endfunction

  assign advance   = !resp_valid || resp_ready;
  assign start_req = ld_start || start_pend;
  assign ld_ready  = (state == LOAD);
  // A reload request (new or pending) closes the fetch port so the pipe can drain.
  assign req_ready = (state == RUN) && !start_req && advance;
  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[AW+1:2];
  assign req_fault = fetch_fault(req_addr, loaded_words);
  assign rd_word   = mem[req_idx];
  assign in_flight = stage_busy || resp_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= LOAD;
      loaded_words <= '0;
      start_pend   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_valid) begin
            loaded_words <= loaded_words + 1'b1;
            if (ld_last || loaded_words == LAST_CNT)
              state <= RUN;
          end
        end
        RUN: begin
          if (start_req) begin
            if (!in_flight) begin
              state        <= LOAD;
              loaded_words <= '0;
              start_pend   <= 1'b0;
            end else begin
              start_pend <= 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Contents survive reset; loaded_words=0 makes them unreadable until reloaded.
  always_ff @(posedge clk) begin
    if (rst_n && state == LOAD && ld_valid)
      mem[loaded_words[AW-1:0]] <= ld_data;
  end

  // ---- stage p1: memory read + fault decision (only present when LAT=2) ----
  if (LAT == 2) begin : g_lat2
    logic        vld_p1;
    logic        fault_p1;
    logic [31:0] data_p1;

    always_ff @(posedge clk) begin
      if (!rst_n)
        vld_p1 <= 1'b0;
      else if (advance)
        vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
      if (advance && accept) begin
        fault_p1 <= req_fault;
        data_p1  <= req_fault ? FILL_WORD : rd_word;
      end
    end

    assign stage_busy = vld_p1;
    assign vld_in     = vld_p1;
    assign fault_in   = fault_p1;
    assign data_in    = data_p1;
  end else begin : g_lat1
    assign stage_busy = 1'b0;
    assign vld_in     = accept;
    assign fault_in   = req_fault;
    assign data_in    = req_fault ? FILL_WORD : rd_word;
  end

  // ---- output stage: response register, held while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_fault <= 1'b0;
    end else if (advance) begin
      resp_valid <= vld_in;
      if (vld_in) begin
        resp_data  <= data_in;
        resp_fault <= fault_in;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: instance 0 is DEPTH=16/LAT=1, instance 1 is DEPTH=64/LAT=2.
// Directed tables and sequences plus a randomized run against a scoreboard model.
`timescale 1ns/1ps
module tb_instr_mem_pipe;

  localparam logic [31:0] FILL = 32'h00000013;

  typedef struct {
    logic [31:0] addr;
    logic        fault;
    logic [31:0] data;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n, ld_valid, ld_last, ld_start, req_valid, resp_ready;
  logic [1:0][31:0] ld_data, req_addr;
  logic             ld_ready0, ld_ready1, req_ready0, req_ready1;
  logic             resp_valid0, resp_valid1, resp_fault0, resp_fault1;
  logic [31:0]      resp_data0, resp_data1;
  logic [4:0]       lw0;
  logic [6:0]       lw1;
  logic [1:0]       ld_ready, req_ready, resp_valid, resp_fault;
  logic [1:0][31:0] resp_data;

  assign ld_ready   = {ld_ready1, ld_ready0};
  assign req_ready  = {req_ready1, req_ready0};
  assign resp_valid = {resp_valid1, resp_valid0};
  assign resp_fault = {resp_fault1, resp_fault0};
  assign resp_data  = {resp_data1, resp_data0};

  instr_mem_pipe #(.DEPTH(16), .LAT(1), .FILL_WORD(FILL)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .ld_valid(ld_valid[0]), .ld_data(ld_data[0]),
    .ld_last(ld_last[0]), .ld_ready(ld_ready0), .ld_start(ld_start[0]),
    .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready0),
    .resp_valid(resp_valid0), .resp_data(resp_data0), .resp_fault(resp_fault0),
    .resp_ready(resp_ready[0]), .loaded_words(lw0));

  instr_mem_pipe #(.DEPTH(64), .LAT(2), .FILL_WORD(FILL)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .ld_valid(ld_valid[1]), .ld_data(ld_data[1]),
    .ld_last(ld_last[1]), .ld_ready(ld_ready1), .ld_start(ld_start[1]),
    .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready1),
    .resp_valid(resp_valid1), .resp_data(resp_data1), .resp_fault(resp_fault1),
    .resp_ready(resp_ready[1]), .loaded_words(lw1));

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mdl_mem [2][64];
  int          mdl_cnt [2] = '{0, 0};
  int          depth_of [2] = '{16, 64};
  int          lat_of [2] = '{1, 2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lw(input int u);
    return (u == 0) ? int'(lw0) : int'(lw1);
  endfunction

  // Reference: word-aligned and below both the loaded count and the depth, else NOP fault.
  function automatic logic [32:0] expect_fetch(input int u, input logic [31:0] a);
    longint widx;
    widx = longint'(a >> 2);
    if (a[1:0] != 2'b00 || widx >= depth_of[u] || widx >= mdl_cnt[u])
      return {1'b1, FILL};
    return {1'b0, mdl_mem[u][int'(widx)]};
  endfunction

  function automatic logic [31:0] rand_addr(input int u);
    int r;
    int c;
    r = int'($urandom_range(0, 9));
    c = mdl_cnt[u];
    if (r < 6 && c > 0) return 32'($urandom_range(0, c - 1)) << 2;
    if (r == 6) return 32'($urandom_range(c, 2 * depth_of[u])) << 2;
    if (r == 7) return (32'($urandom_range(0, depth_of[u] - 1)) << 2) | 32'($urandom_range(1, 3));
    if (r == 8) return $urandom;
    return 32'(depth_of[u]) << 2;
  endfunction

  task automatic idle(input int u);
    ld_valid[u]   = 1'b0;
    ld_last[u]    = 1'b0;
    ld_start[u]   = 1'b0;
    req_valid[u]  = 1'b0;
    resp_ready[u] = 1'b1;
    ld_data[u]    = 32'h0;
    req_addr[u]   = 32'h0;
  endtask

  task automatic load_words(input int u, input logic [31:0] words[$], input bit last_at_end,
                            input bit gaps);
    int n;
    n = words.size();
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          ld_valid[u] = 1'b0;
          tick();
        end
      end
      ld_valid[u] = 1'b1;
      ld_data[u]  = words[i];
      ld_last[u]  = last_at_end && (i == n - 1);
      @(negedge clk);
      chk("ld_ready_in_load", ld_ready[u], 1);
      chk("lw_during_load", lw(u), i);
      tick();
      mdl_mem[u][i] = words[i];
      mdl_cnt[u]    = i + 1;
    end
    ld_valid[u] = 1'b0;
    ld_last[u]  = 1'b0;
    @(negedge clk);
    chk("ld_ready_in_run", ld_ready[u], 0);
    chk("lw_after_load", lw(u), n);
    tick();
  endtask

  // Single fetch on the LAT=1 instance with an explicit expected response.
  task automatic fetch1(input int u, input logic [31:0] addr, input logic ef,
                        input logic [31:0] ed);
    req_valid[u]  = 1'b1;
    req_addr[u]   = addr;
    resp_ready[u] = 1'b1;
    @(negedge clk);
    chk("fetch_req_ready", req_ready[u], 1);
    tick();
    req_valid[u] = 1'b0;
    @(negedge clk);
    chk("fetch_resp_valid", resp_valid[u], 1);
    chk("fetch_resp_fault", resp_fault[u], ef);
    chk("fetch_resp_data", resp_data[u], ed);
    tick();
    @(negedge clk);
    chk("fetch_resp_clear", resp_valid[u], 0);
    tick();
  endtask

  task automatic enter_load(input int u);
    bit seen;
    seen = 1'b0;
    ld_start[u] = 1'b1;
    @(negedge clk);
    chk("start_blocks_req", req_ready[u], 0);
    tick();
    ld_start[u] = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (ld_ready[u]) seen = 1'b1;
      else tick();
    end
    chk("enter_load", seen, 1);
    chk("lw_cleared", lw(u), 0);
    tick();
    mdl_cnt[u] = 0;
  endtask

  // Scoreboard stream: response k must appear at max(accept_k + LAT, pop_{k-1} + 1).
  task automatic stream(input int u, input logic [31:0] addrs[$], input bit rnd,
                        input int stall_at, input int stall_len);
    int          n;
    int          sent;
    int          got;
    int          hold;
    int          cyc;
    int          last_pop;
    int          due;
    logic [32:0] q[$];
    int          acc[$];
    logic [32:0] h;
    bit          mv;
    n = addrs.size();
    sent = 0; got = 0; hold = 0; cyc = 0; last_pop = -100;
    while (got < n && cyc < 400) begin
      mv = 1'b0;
      if (q.size() > 0) begin
        due = (acc[0] + lat_of[u] > last_pop + 1) ? acc[0] + lat_of[u] : last_pop + 1;
        mv  = (cyc >= due);
      end
      req_valid[u] = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
      req_addr[u]  = (sent < n) ? addrs[sent] : 32'h0;
      if (rnd) resp_ready[u] = ($urandom_range(0, 2) != 0);
      else     resp_ready[u] = !(mv && got == stall_at && hold < stall_len);
      @(negedge clk);
      chk("s_resp_valid", resp_valid[u], mv);
      chk("s_req_ready", req_ready[u], !mv || resp_ready[u]);
      if (mv && resp_valid[u]) begin
        h = q[0];
        chk("s_resp_fault", resp_fault[u], h[32]);
        chk("s_resp_data", resp_data[u], h[31:0]);
      end
      if (mv && !resp_ready[u] && got == stall_at) hold++;
      if (mv && resp_ready[u]) begin
        void'(q.pop_front());
        void'(acc.pop_front());
        got++;
        last_pop = cyc;
      end
      if (req_valid[u] && req_ready[u]) begin
        q.push_back(expect_fetch(u, addrs[sent]));
        acc.push_back(cyc);
        sent++;
      end
      tick();
      cyc++;
    end
    chk("s_all_responses", got, n);
    req_valid[u]  = 1'b0;
    resp_ready[u] = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog[$];
    logic [31:0] words[$];
    logic [31:0] addrs[$];
    vec_t        tbl [7];
    int          n;
    bit          lastf;

    prog = '{32'h00100093, 32'h00200113, 32'h0020c463};
    tbl[0] = '{32'h00000008, 1'b0, 32'h0020c463};
    tbl[1] = '{32'h00000000, 1'b0, 32'h00100093};
    tbl[2] = '{32'h00000004, 1'b0, 32'h00200113};
    tbl[3] = '{32'h0000000C, 1'b1, FILL};
    tbl[4] = '{32'h00000006, 1'b1, FILL};
    tbl[5] = '{32'h00000040, 1'b1, FILL};
    tbl[6] = '{32'hFFFFFFF8, 1'b1, FILL};

    for (int u = 0; u < 2; u++) begin
      idle(u);
      rst_n[u] = 1'b0;
    end
    tick();
    tick();
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_ld_ready", ld_ready[u], 1);
      chk("rst_req_ready", req_ready[u], 0);
      chk("rst_resp_valid", resp_valid[u], 0);
      chk("rst_resp_fault", resp_fault[u], 0);
      chk("rst_resp_data", resp_data[u], 0);
      chk("rst_lw", lw(u), 0);
    end
    tick();
    rst_n = 2'b11;

    // Instance 0: three-word program, then table of single fetches.
    load_words(0, prog, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)
      fetch1(0, tbl[i].addr, tbl[i].fault, tbl[i].data);

    // ld_start while a response is held: LOAD only after the consumer drains it.
    req_valid[0]  = 1'b1;
    req_addr[0]   = 32'h0;
    resp_ready[0] = 1'b0;
    @(negedge clk);
    chk("hold_req_ready", req_ready[0], 1);
    tick();
    req_valid[0] = 1'b0;
    ld_start[0]  = 1'b1;
    @(negedge clk);
    chk("hold_resp_valid", resp_valid[0], 1);
    chk("hold_start_req_ready", req_ready[0], 0);
    tick();
    ld_start[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("no_load_while_held", ld_ready[0], 0);
      chk("held_resp_valid", resp_valid[0], 1);
      chk("held_resp_data", resp_data[0], 32'h00100093);
      tick();
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("pending_start_req_ready", req_ready[0], 0);
    tick();
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
        @(negedge clk);
        if (ld_ready[0]) seen = 1'b1;
        else tick();
      end
      chk("drained_enter_load", seen, 1);
      chk("drained_lw", lw(0), 0);
      chk("drained_resp_valid", resp_valid[0], 0);
      tick();
    end
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0;
    repeat (2) begin
      @(negedge clk);
      chk("load_blocks_fetch", req_ready[0], 0);
      chk("load_no_resp", resp_valid[0], 0);
      tick();
    end
    req_valid[0] = 1'b0;
    words = '{32'hDEAD0001, 32'hDEAD0002};
    load_words(0, words, 1'b1, 1'b0);
    fetch1(0, 32'h8, 1'b1, FILL);
    fetch1(0, 32'h0, 1'b0, 32'hDEAD0001);

    // Fill all 16 words without ld_last: RUN after the 16th.
    enter_load(0);
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back($urandom);
    load_words(0, words, 1'b0, 1'b1);
    fetch1(0, 32'h40, 1'b1, FILL);
    fetch1(0, 32'h3C, 1'b0, words[15]);

    // Reset while the second loader word is presented.
    enter_load(0);
    ld_valid[0] = 1'b1;
    ld_data[0]  = 32'hAAAA0001;
    tick();
    ld_data[0] = 32'hAAAA0002;
    rst_n[0]   = 1'b0;
    tick();
    rst_n[0]    = 1'b1;
    ld_valid[0] = 1'b0;
    @(negedge clk);
    chk("midload_rst_lw", lw(0), 0);
    chk("midload_rst_ld_ready", ld_ready[0], 1);
    chk("midload_rst_resp_valid", resp_valid[0], 0);
    tick();

    // Instance 1 (LAT=2): back-to-back fetches with a 3-cycle stall on the first response.
    load_words(1, prog, 1'b1, 1'b0);
    addrs = '{32'h0, 32'h4, 32'h8, 32'h0};
    stream(1, addrs, 1'b0, 0, 3);

    // Reset with a request inside the pipeline: no response may surface.
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h4;
    @(negedge clk);
    chk("flight_req_ready", req_ready[1], 1);
    tick();
    req_valid[1] = 1'b0;
    rst_n[1]     = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_resp_after_rst", resp_valid[1], 0);
      tick();
    end
    @(negedge clk);
    chk("flight_rst_lw", lw(1), 0);
    chk("flight_rst_ld_ready", ld_ready[1], 1);
    tick();
    mdl_cnt[1] = 0;

    // Randomized rounds on instance 1.
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(3, 64));
      lastf = (n < 64) ? 1'b1 : 1'($urandom_range(0, 1));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      load_words(1, words, lastf, 1'b1);
      addrs.delete();
      for (int i = 0; i < 80; i++) addrs.push_back(rand_addr(1));
      stream(1, addrs, 1'b1, 0, 0);
      enter_load(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
